// File: rtl/tile_scheduler.sv
// K-dimension tile sequencer for the matmul engine.
// Ports: clk/reset, start/abort control, latched tile parameters
// (num_tiles, base_addr_a/b, tile_step_a/b), done_mat_mul handshake in;
// start_mat_mul, A/B tile addresses, accumulate flags, tile_idx, busy and
// done out. All outputs are registered.
module tile_scheduler #(
    parameter int AWIDTH    = 10,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] num_tiles,
    input  logic [AWIDTH-1:0]    base_addr_a,
    input  logic [AWIDTH-1:0]    base_addr_b,
    input  logic [AWIDTH-1:0]    tile_step_a,
    input  logic [AWIDTH-1:0]    tile_step_b,
    input  logic                 done_mat_mul,
    output logic                 start_mat_mul,
    output logic [AWIDTH-1:0]    address_mat_a,
    output logic [AWIDTH-1:0]    address_mat_b,
    output logic                 save_output_to_accum,
    output logic                 add_accum_to_output,
    output logic [CNT_WIDTH-1:0] tile_idx,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, SETUP, RUN, GAP} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [AWIDTH-1:0]    step_a_q, step_a_d;
    logic [AWIDTH-1:0]    step_b_q, step_b_d;
    logic [AWIDTH-1:0]    addr_a_q, addr_a_d;
    logic [AWIDTH-1:0]    addr_b_q, addr_b_d;
    logic [CNT_WIDTH-1:0] idx_q, idx_d;
    logic                 smm_q, smm_d;
    logic                 save_q, save_d;
    logic                 add_q, add_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 last_tile;

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        step_a_d  = step_a_q;
        step_b_d  = step_b_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        idx_d     = idx_q;
        smm_d     = smm_q;
        save_d    = save_q;
        add_d     = add_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        last_tile = (idx_q == num_q - CNT_WIDTH'(1));

        unique case (state_q)
            IDLE: begin
                // abort in the same cycle suppresses a start request
                if (start && !abort) begin
                    if (num_tiles != '0) begin
                        num_d    = num_tiles;
                        step_a_d = tile_step_a;
                        step_b_d = tile_step_b;
                        addr_a_d = base_addr_a;
                        addr_b_d = base_addr_b;
                        idx_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = SETUP;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                smm_d   = 1'b1;
                save_d  = !last_tile;
                add_d   = (idx_q != '0);
                state_d = RUN;
            end
            RUN: begin
                if (done_mat_mul) begin
                    smm_d = 1'b0;
                    if (last_tile) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        save_d  = 1'b0;
                        add_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                // start_mat_mul stays low here so matmul clears its counters
                idx_d    = idx_q + CNT_WIDTH'(1);
                addr_a_d = addr_a_q + step_a_q;
                addr_b_d = addr_b_q + step_b_q;
                state_d  = SETUP;
            end
            default: state_d = IDLE;
        endcase

        // abort overrides everything the case computed, including done
        if (abort && state_q != IDLE) begin
            smm_d    = 1'b0;
            busy_d   = 1'b0;
            save_d   = 1'b0;
            add_d    = 1'b0;
            done_d   = 1'b0;
            addr_a_d = addr_a_q;
            addr_b_d = addr_b_q;
            idx_d    = idx_q;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            num_q    <= '0;
            step_a_q <= '0;
            step_b_q <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            idx_q    <= '0;
            smm_q    <= 1'b0;
            save_q   <= 1'b0;
            add_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            step_a_q <= step_a_d;
            step_b_q <= step_b_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            idx_q    <= idx_d;
            smm_q    <= smm_d;
            save_q   <= save_d;
            add_q    <= add_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign start_mat_mul        = smm_q;
    assign address_mat_a        = addr_a_q;
    assign address_mat_b        = addr_b_q;
    assign save_output_to_accum = save_q;
    assign add_accum_to_output  = add_q;
    assign tile_idx             = idx_q;
    assign busy                 = busy_q;
    assign done                 = done_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Scoreboard bench for tile_scheduler: expected tile passes are queued at
// launch and compared on each rising start_mat_mul.
module tb_tile_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] num_tiles = '0;
    logic [9:0] base_addr_a = '0;
    logic [9:0] base_addr_b = '0;
    logic [9:0] tile_step_a = '0;
    logic [9:0] tile_step_b = '0;
    logic       done_mat_mul = 1'b0;
    logic       start_mat_mul;
    logic [9:0] address_mat_a;
    logic [9:0] address_mat_b;
    logic       save_output_to_accum;
    logic       add_accum_to_output;
    logic [7:0] tile_idx;
    logic       busy;
    logic       done;

    tile_scheduler #(.AWIDTH(10), .CNT_WIDTH(8)) dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .abort                (abort),
        .num_tiles            (num_tiles),
        .base_addr_a          (base_addr_a),
        .base_addr_b          (base_addr_b),
        .tile_step_a          (tile_step_a),
        .tile_step_b          (tile_step_b),
        .done_mat_mul         (done_mat_mul),
        .start_mat_mul        (start_mat_mul),
        .address_mat_a        (address_mat_a),
        .address_mat_b        (address_mat_b),
        .save_output_to_accum (save_output_to_accum),
        .add_accum_to_output  (add_accum_to_output),
        .tile_idx             (tile_idx),
        .busy                 (busy),
        .done                 (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] a;
        logic [9:0] b;
        logic       save;
        logic       add;
        logic [7:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   passes = 0;
    int   done_seen = 0;
    logic smm_prev = 1'b0;
    int   mm_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // matmul model: done_mat_mul rises 10 cycles into a pass and stays
    // high until start_mat_mul drops
    always @(posedge clk) begin
        #1;
        if (!start_mat_mul) begin
            mm_cnt = 0;
            done_mat_mul = 1'b0;
        end else begin
            mm_cnt++;
            if (mm_cnt >= 10) done_mat_mul = 1'b1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done) done_seen++;
        if (start_mat_mul && !smm_prev) begin
            passes++;
            if (exp_q.size() == 0) begin
                check("spurious_pass", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("addr_a", 32'(address_mat_a), 32'(e.a));
                check("addr_b", 32'(address_mat_b), 32'(e.b));
                check("save", 32'(save_output_to_accum), 32'(e.save));
                check("add", 32'(add_accum_to_output), 32'(e.add));
                check("tile_idx", 32'(tile_idx), 32'(e.idx));
            end
        end
        smm_prev = start_mat_mul;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_smm"}, 32'(start_mat_mul), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
        check({tag, "_save"}, 32'(save_output_to_accum), 32'(0));
        check({tag, "_add"}, 32'(add_accum_to_output), 32'(0));
        check({tag, "_addr_a"}, 32'(address_mat_a), 32'(0));
        check({tag, "_addr_b"}, 32'(address_mat_b), 32'(0));
        check({tag, "_idx"}, 32'(tile_idx), 32'(0));
    endtask

    task automatic launch(input int n, input logic [9:0] ba,
                          input logic [9:0] bb, input logic [9:0] sa,
                          input logic [9:0] sb);
        exp_t e;
        logic [9:0] a, b;
        a = ba;
        b = bb;
        for (int i = 0; i < n; i++) begin
            e.a = a;
            e.b = b;
            e.save = (i != n - 1);
            e.add = (i != 0);
            e.idx = 8'(i);
            exp_q.push_back(e);
            a = a + sa;
            b = b + sb;
        end
        start = 1'b1;
        num_tiles = 8'(n);
        base_addr_a = ba;
        base_addr_b = bb;
        tile_step_a = sa;
        tile_step_b = sb;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            step();
            k++;
        end
        if (!done) begin
            check({tag, "_timeout"}, 32'(0), 32'(1));
        end else begin
            check({tag, "_busy_end"}, 32'(busy), 32'(0));
            check({tag, "_smm_end"}, 32'(start_mat_mul), 32'(0));
            check({tag, "_q_empty"}, 32'(exp_q.size()), 32'(0));
            step();
            check({tag, "_done_pulse"}, 32'(done), 32'(0));
        end
    endtask

    task automatic wait_passes(input string tag, input int target);
        int k;
        k = 0;
        while (passes < target && k < 200) begin
            step();
            k++;
        end
        if (passes < target) check({tag, "_pass_timeout"}, 32'(0), 32'(1));
    endtask

    initial begin
        int d0, p0;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        // three tiles, chained accumulation
        d0 = done_seen;
        launch(3, 10'h010, 10'h020, 10'd4, 10'd8);
        check("t1_busy", 32'(busy), 32'(1));
        check("t1_setup_smm", 32'(start_mat_mul), 32'(0));
        wait_done("t1", 200);
        check("t1_done_cnt", 32'(done_seen - d0), 32'(1));
        step();

        // single tile near the top of the address space
        d0 = done_seen;
        launch(1, 10'h3FC, 10'h100, 10'd4, 10'd4);
        begin
            int k;
            k = 0;
            while (!done_mat_mul && k < 100) begin
                step();
                k++;
            end
        end
        check("t2_mm_done_seen", 32'(done_mat_mul), 32'(1));
        step();
        check("t2_done_now", 32'(done), 32'(1));
        check("t2_smm_low", 32'(start_mat_mul), 32'(0));
        check("t2_busy_low", 32'(busy), 32'(0));
        step();
        check("t2_done_clear", 32'(done), 32'(0));
        check("t2_smm_low2", 32'(start_mat_mul), 32'(0));
        check("t2_done_cnt", 32'(done_seen - d0), 32'(1));
        check("t2_q_empty", 32'(exp_q.size()), 32'(0));
        step();

        // zero tiles: immediate done, no pass
        d0 = done_seen;
        p0 = passes;
        launch(0, 10'h055, 10'h066, 10'd1, 10'd1);
        check("t3_done", 32'(done), 32'(1));
        check("t3_busy", 32'(busy), 32'(0));
        step();
        check("t3_done_clear", 32'(done), 32'(0));
        repeat (5) step();
        check("t3_no_pass", 32'(passes - p0), 32'(0));
        check("t3_done_cnt", 32'(done_seen - d0), 32'(1));

        // address wrap on the second tile
        launch(2, 10'h3FE, 10'h000, 10'd4, 10'd2);
        wait_done("t4", 200);
        step();

        // start while busy must not disturb the running sequence
        d0 = done_seen;
        p0 = passes;
        launch(3, 10'h040, 10'h080, 10'd16, 10'd32);
        wait_passes("t5", p0 + 2);
        step();
        start = 1'b1;
        num_tiles = 8'd5;
        base_addr_a = 10'h200;
        base_addr_b = 10'h300;
        tile_step_a = 10'd1;
        tile_step_b = 10'd1;
        step();
        start = 1'b0;
        wait_done("t5", 200);
        check("t5_done_cnt", 32'(done_seen - d0), 32'(1));
        check("t5_passes", 32'(passes - p0), 32'(3));
        step();

        // abort during tile 1 of 4
        d0 = done_seen;
        p0 = passes;
        launch(4, 10'h011, 10'h022, 10'd3, 10'd5);
        wait_passes("t6", p0 + 2);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t6_smm", 32'(start_mat_mul), 32'(0));
        check("t6_busy", 32'(busy), 32'(0));
        check("t6_done", 32'(done), 32'(0));
        check("t6_idx_hold", 32'(tile_idx), 32'(1));
        check("t6_addr_a_hold", 32'(address_mat_a), 32'(10'h014));
        check("t6_addr_b_hold", 32'(address_mat_b), 32'(10'h027));
        exp_q.delete();
        repeat (15) step();
        check("t6_no_done", 32'(done_seen - d0), 32'(0));
        check("t6_no_pass", 32'(passes - p0), 32'(2));
        launch(2, 10'h123, 10'h234, 10'd7, 10'd9);
        wait_done("t6b", 200);
        check("t6b_done_cnt", 32'(done_seen - d0), 32'(1));
        step();

        // reset mid-sequence
        d0 = done_seen;
        p0 = passes;
        launch(4, 10'h011, 10'h022, 10'd3, 10'd5);
        wait_passes("t7", p0 + 2);
        step();
        reset = 1'b1;
        step();
        check_all_zero("t7_reset");
        reset = 1'b0;
        exp_q.delete();
        repeat (15) step();
        check("t7_no_done", 32'(done_seen - d0), 32'(0));
        check("t7_no_pass", 32'(passes - p0), 32'(2));
        launch(2, 10'h001, 10'h002, 10'd1, 10'd1);
        wait_done("t7b", 200);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
